// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into one APB transfer at a time.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel_x,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

    state_t state;

    assign cmd_ready = (state == StIdle);

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       timed_out;

    // pready wins in the threshold cycle, so only a low pready can abort.
    assign timed_out = !pready && (wait_cnt == WaitLast);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= StIdle;
            psel_x      <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt    <= 8'd0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    psel_x  <= 1'b0;
                    penable <= 1'b0;
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel_x <= 1'b1;
                        state  <= StSetup;
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    state   <= StAccess;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= 8'd0;
`endif
                end
                StAccess: begin
                    if (pready) begin
                        state       <= StIdle;
                        psel_x      <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_timeout <= 1'b0;
`ifdef APB_TIMEOUT_EN
                    end else if (timed_out) begin
                        state       <= StIdle;
                        psel_x      <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    state   <= StIdle;
                    psel_x  <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: a scripted APB completer plus a
// response monitor that checks contents and latency against queued predictions.
module tb_apb_requester;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel_x;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    apb_requester #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel_x     (psel_x),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Plan for the transfer currently on the bus.
    logic          p_write = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [DW-1:0] p_rdata = '0;
    logic          p_err = 1'b0;
    int            p_waits = 0;
    int            acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completer: answers after p_waits wait states, drives noise outside ACCESS.
    always @(negedge pclk) begin
        if (!preset) begin
            check("cmd_ready_vs_idle", cmd_ready, !psel_x);
            if (psel_x && !penable) begin
                check("setup_paddr", paddr, p_addr);
                check("setup_pwrite", pwrite, p_write);
                check("setup_pwdata", pwdata, p_wdata);
                acc = 0;
            end
            if (psel_x && penable) begin
                check("access_paddr", paddr, p_addr);
                check("access_pwrite", pwrite, p_write);
                check("access_pwdata", pwdata, p_wdata);
                if (acc == p_waits) begin
                    pready  = 1'b1;
                    prdata  = p_rdata;
                    pslverr = p_err;
                end else begin
                    pready  = 1'b0;
                    prdata  = DW'($urandom);
                    pslverr = 1'($urandom);
                end
                acc++;
            end else begin
                pready  = 1'($urandom);
                prdata  = DW'($urandom);
                pslverr = 1'($urandom);
            end
        end
    end

    // Response monitor.
    always @(negedge pclk) begin
        if (!preset && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
                check("rsp_timeout", rsp_timeout, e.tmo);
                check("rsp_latency", cyc, e.due);
            end
        end
    end

    // Call at a negedge; returns at the negedge after the handshake.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic [DW-1:0] rd, input logic err,
                         input bit hold, input bit b2b);
        int   bound;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        bound = 0;
        while (!cmd_ready && bound < 200) begin
            @(negedge pclk);
            bound++;
        end
        if (!cmd_ready) begin
            check("handshake_wait", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) check("b2b_rsp_with_handshake", rsp_valid, 1'b1);
        p_write = w;
        p_addr  = a;
        p_wdata = d;
        p_rdata = rd;
        p_err   = err;
        p_waits = waits;
        e.rdata = w ? '0 : rd;
        e.err   = err;
        e.tmo   = 1'b0;
        e.due   = cyc + 3 + waits;
`ifdef APB_TIMEOUT_EN
        if (waits >= TO) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.tmo   = 1'b1;
            e.due   = cyc + 3 + TO - 1;
        end
`endif
        sb.push_back(e);
        @(negedge pclk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"}, psel_x, 1'b0);
        check({tag, "_penable"}, penable, 1'b0);
        check({tag, "_pwrite"}, pwrite, 1'b0);
        check({tag, "_paddr"}, paddr, '0);
        check({tag, "_pwdata"}, pwdata, '0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check({tag, "_rsp_err"}, rsp_err, 1'b0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge pclk);
    endtask

    initial begin
        #1 check_all_zero("reset");
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // Directed cases.
        issue(1'b1, 3'd2, 8'hA5, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(3);
        issue(1'b0, 3'd4, 8'h00, 2, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(5);
        issue(1'b1, 3'd1, 8'h5A, 0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3);
        issue(1'b0, 3'd3, 8'h00, 0, 8'hC7, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 3'd4, 8'h11, 1, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Reset in the middle of a read's ACCESS phase.
        issue(1'b0, 3'd5, 8'h00, 6, 8'h99, 1'b0, 1'b0, 1'b0);
        @(negedge pclk);
        check("pre_reset_in_access", {psel_x, penable}, 2'b11);
        #2 preset = 1'b1;
        #1 check_all_zero("mid_reset");
        sb.delete();
        @(negedge pclk);
        preset = 1'b0;
        idle(3);
        issue(1'b0, 3'd6, 8'h00, 1, 8'h42, 1'b0, 1'b0, 1'b0);
        idle(5);

`ifdef APB_TIMEOUT_EN
        issue(1'b1, 3'd7, 8'h77, 1000, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(TO + 4);
        issue(1'b0, 3'd2, 8'h00, TO - 1, 8'h6E, 1'b0, 1'b0, 1'b0);
        idle(TO + 4);
`endif

        // Randomized traffic, some back-to-back with cmd_valid held.
        begin
            bit prev_hold = 1'b0;
            for (int i = 0; i < 40; i++) begin
                bit hold;
                hold = (i != 39) && ($urandom_range(0, 1) == 1);
                issue(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 4)),
                      DW'($urandom), ($urandom_range(0, 3) == 0), hold, prev_hold);
                prev_hold = hold;
                if (!hold) idle(int'($urandom_range(0, 3)));
            end
        end

        begin
            int bound = 0;
            while (sb.size() != 0 && bound < 300) begin
                @(negedge pclk);
                bound++;
            end
            check("drain_pending", sb.size(), 0);
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB requester that converts a simple valid/ready command interface into APB transfers, one at a time. It drives a single completer select and runs the IDLE/SETUP/ACCESS protocol FSM. It samples PREADY, PRDATA and PSLVERR and returns a one-cycle response pulse. It sits between the host/control logic and the APB completer's address-mapping/register logic.

Parameters:
ADDR_WIDTH, 3, width of cmd_addr/paddr
DATA_WIDTH, 8, width of write/read data
TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with pready low before abort (used only with APB_TIMEOUT_EN); legal range 2..255

Ports:
pclk  input  1  clock; all state changes on rising edge
preset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
rsp_err  output  1  transfer ended with pslverr or timeout
rsp_timeout  output  1  transfer aborted by timeout
psel_x  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Reset (async assert, sync release): state=IDLE; psel_x, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
- Reset asserted mid-transfer: the transfer is dropped immediately and no response is issued.
- cmd_ready = (state==IDLE), combinational. There is no command buffering.
- IDLE: psel_x=0, penable=0. On handshake, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP: psel_x=1, penable=0. Always go to ACCESS next cycle.
- ACCESS: psel_x=1, penable=1. pwrite/paddr/pwdata are held stable.
  - pready=0: stay in ACCESS (wait state).
  - pready=1: go to IDLE. Next cycle rsp_valid=1 for exactly one cycle.
  - Response contents: rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes; rsp_timeout=0.
- pready, prdata and pslverr are ignored outside ACCESS.
- Latency: handshake in cycle N gives SETUP in N+1, ACCESS in N+2. Zero-wait completion samples pready in N+2; rsp_valid is high in N+3, same cycle cmd_ready returns high.
- Minimum issue interval is 3 cycles. ACCESS never goes directly to SETUP.
- After completion, paddr/pwrite/pwdata hold their last values until the next handshake.
- rsp_rdata/rsp_err/rsp_timeout hold their values until the next response. rsp_valid has no backpressure.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: an 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES-1 with pready still 0, the transfer aborts: psel_x/penable deassert, state goes to IDLE, and next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- pready=1 in the threshold cycle completes normally; pready wins.
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Write addr 2, data 0xA5, pready=1 at ACCESS -> SETUP with paddr=2, pwdata=0xA5, pwrite=1; rsp_valid 3 cycles after handshake; rsp_err=0, rsp_rdata=0x00.
- Read addr 4 with pready low for 2 ACCESS cycles, then prdata=0x3C, pready=1 -> penable high 3 cycles; paddr stable; rsp_rdata=0x3C, rsp_err=0.
- Write addr 1 with pslverr=1, pready=1 -> rsp_err=1, rsp_timeout=0; FSM returns to IDLE.
- cmd_valid held high for two commands (read 3, write 4/0x11) -> cmd_ready low during SETUP/ACCESS; second handshake in the same cycle as the first rsp_valid; both transfers correct.
- preset pulsed during ACCESS of a read -> all outputs 0 asynchronously; no rsp_valid; next command runs normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready stuck 0 -> abort after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1. Repeat with pready=1 in the 8th cycle -> normal completion, rsp_timeout=0.
